usb_wb_arbiter: RTL
===================

# usb_wb_arbiter

Round-robin Wishbone (classic, non-pipelined) arbiter that shares the single Wishbone slave port of `usb_device` between `NUM_M` bus masters, e.g. the host CPU and a USB endpoint DMA engine. It grants whole bus cycles (held while the owner keeps `cyc` high) and muxes the request and response paths. A per-transfer watchdog terminates hung transfers with an error, so a stalled USB core cannot lock the bus. It sits between the system interconnect and `usb_top_wrp` and runs entirely in the `i_wb_clk` domain.

## Interface
- `NUM_M`, default 2: number of masters, 2..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width; `SW = DW/8` select width.
- `TIMEOUT`, default 255: wait cycles allowed per transfer before error, 1..65535.
- `i_wb_clk`, in, 1: the only clock.
- `i_wb_rst_n`, in, 1: asynchronous, active-low reset.
- `i_m_cyc`, in, NUM_M: per-master `cyc`.
- `i_m_stb`, in, NUM_M: per-master `stb`.
- `i_m_we`, in, NUM_M: per-master `we`.
- `i_m_adr`, in, NUM_M*AW: packed addresses, master k at `[k*AW +: AW]`.
- `i_m_dat`, in, NUM_M*DW: packed write data.
- `i_m_sel`, in, NUM_M*SW: packed byte selects.
- `o_m_ack`, out, NUM_M: ack routed to the owner only.
- `o_m_err`, out, NUM_M: one-cycle timeout error to the owner.
- `o_m_dat`, out, DW: read data, broadcast to all masters.
- `o_s_cyc`, `o_s_stb`, `o_s_we`, out, 1 each: slave side.
- `o_s_adr`, out, AW; `o_s_dat`, out, DW; `o_s_sel`, out, SW: slave side.
- `i_s_ack`, in, 1; `i_s_dat`, in, DW: slave response.
- `o_grant`, out, $clog2(NUM_M): current or last owner index, for debug.
- `o_busy`, out, 1: high in states BUSY and ERR.

## Operation
- FSM with three states:
  - IDLE: no owner; all slave strobes low.
  - BUSY: the owner's `cyc` is forwarded.
  - ERR: transfer aborted; waiting for the owner to drop `cyc`.
- IDLE: if any `i_m_cyc` is high, pick the first requester scanning from `last+1` modulo NUM_M. Register it in `grant` and `last`, then go to BUSY.
- BUSY:
  - `o_s_cyc = 1`.
  - `o_s_stb/we/adr/dat/sel` driven combinationally from master `grant`.
  - `o_m_ack[grant] = i_s_ack & i_m_stb[grant]`.
  - `o_m_dat = i_s_dat` at all times.
  - The owner may issue back-to-back transfers without re-arbitration.
- BUSY → IDLE when `i_m_cyc[grant]` is low; the slave-side `cyc` drops combinationally that same cycle.
- Watchdog, a 16-bit counter:
  - Clears on reset, on entry to BUSY, and in any cycle with `o_s_stb & i_s_ack`.
  - Increments while `o_s_stb & ~i_s_ack`.
  - When the count equals TIMEOUT with no ack: pulse `o_m_err[grant]` for one cycle and go to ERR. From that cycle on, `o_s_cyc` and `o_s_stb` are 0.
- ERR → IDLE when `i_m_cyc[grant]` is low. A late `i_s_ack` in ERR is ignored.
- Simultaneous ack and count==TIMEOUT: ack wins, no error.
- Requests from non-owners are ignored until IDLE. Their `o_m_ack`/`o_m_err` stay 0.
- Reset mid-transfer: everything is cleared asynchronously. The slave sees `cyc` drop immediately.

## Timing
- Reset values:
  - All `o_m_ack`, `o_m_err`, `o_s_*` control and data outputs = 0.
  - `o_busy = 0`.
  - `o_grant = 0`; internal `last = NUM_M-1`, so master 0 wins the first tie.
- Grant latency: one clock from `cyc` rising in IDLE to `o_s_cyc` high.
- Re-arbitration gap: at least one IDLE cycle between owners.
- Ack/data path is combinational, with zero added latency inside a granted cycle.
- Error is asserted in the cycle where the counter equals TIMEOUT, i.e. after TIMEOUT unacked stb cycles.

## Structure
- Shared package `usb_wb_pkg`: `arb_state_t` enum (IDLE, BUSY, ERR) and the default AW/DW constants.
- One natural sub-module: `usb_rr_pick`, a combinational round-robin priority picker (request vector plus last index → grant index and valid).
- Instantiated ahead of `usb_top_wrp`'s `wbs` interface.

## Test plan
- Single master 0 write: `cyc`/`stb` with adr 0x10, dat 0xDEADBEEF, slave acks after 3 cycles → slave sees the same adr/dat. `o_m_ack[0]` pulses once. `o_s_cyc` rises 1 clk after request.
- Both masters request in the same cycle from reset → master 0 granted first. After 0 drops `cyc`: 1 IDLE cycle, then master 1 granted, then master 0 again (alternation over 4 cycles).
- Master 1 does 3 back-to-back reads while master 0 requests → master 0 waits. `o_m_ack[0]` never asserts until master 1 releases.
- TIMEOUT=8, slave never acks → `o_m_err[grant]` high exactly on the 8th stb cycle, `o_s_stb` 0 after, FSM in ERR until `cyc` drops.
- Slave acks on exactly the 8th cycle (TIMEOUT=8) → ack delivered, no error.
- Assert `i_wb_rst_n` low mid-BUSY → all outputs 0 asynchronously. After release, master 0 wins the first tie.

Source files
------------

// File: rtl/usb_wb_pkg.sv
// Shared types and default widths for the USB Wishbone arbiter slice.
package usb_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  localparam int WB_AW  = 32;
  localparam int WB_DW  = 32;
  localparam int WDOG_W = 16;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first requester scanning from last+1 modulo N.
module usb_rr_pick #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] grant,
  output logic          valid
);

  logic [GW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // The previous owner is visited last, so it only wins when nobody else asks.
    for (int i = 1; i <= N; i++) begin
      idx = GW'((int'(last) + i) % N);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_wb_arbiter.sv
// Round-robin Wishbone classic arbiter in front of the usb_device slave port,
// with a per-transfer watchdog that aborts hung transfers with an error.
module usb_wb_arbiter
  import usb_wb_pkg::*;
#(
  parameter  int NUM_M   = 2,
  parameter  int AW      = WB_AW,
  parameter  int DW      = WB_DW,
  parameter  int TIMEOUT = 255,
  localparam int SW      = DW / 8,
  localparam int GW      = $clog2(NUM_M)
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic [NUM_M-1:0]    i_m_cyc,
  input  logic [NUM_M-1:0]    i_m_stb,
  input  logic [NUM_M-1:0]    i_m_we,
  input  logic [NUM_M*AW-1:0] i_m_adr,
  input  logic [NUM_M*DW-1:0] i_m_dat,
  input  logic [NUM_M*SW-1:0] i_m_sel,
  output logic [NUM_M-1:0]    o_m_ack,
  output logic [NUM_M-1:0]    o_m_err,
  output logic [DW-1:0]       o_m_dat,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [AW-1:0]     o_s_adr,
  output logic [DW-1:0]     o_s_dat,
  output logic [SW-1:0]     o_s_sel,
  input  logic              i_s_ack,
  input  logic [DW-1:0]     i_s_dat,
  output logic [GW-1:0]     o_grant,
  output logic              o_busy
);

  arb_state_t        state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last;
  logic [WDOG_W-1:0] wdog;
  logic [GW-1:0]     pick;
  logic              pick_vld;
  logic              fwd;
  logic              s_stb;
  logic              timeout_hit;

  usb_rr_pick #(
    .N  (NUM_M),
    .GW (GW)
  ) u_pick (
    .req   (i_m_cyc),
    .last  (last),
    .grant (pick),
    .valid (pick_vld)
  );

  // The owner's cyc gates everything so the slave sees cyc fall in the same cycle.
  always_comb begin
    fwd         = (state == BUSY) && i_m_cyc[grant];
    s_stb       = fwd && i_m_stb[grant];
    // wdog counts completed wait cycles, so this is the TIMEOUT-th unacked stb cycle.
    timeout_hit = s_stb && !i_s_ack && (wdog == WDOG_W'(TIMEOUT - 1));
  end

  assign o_s_cyc = fwd;
  assign o_s_stb = s_stb;
  assign o_s_we  = fwd && i_m_we[grant];
  assign o_s_adr = fwd ? i_m_adr[grant*AW +: AW] : '0;
  assign o_s_dat = fwd ? i_m_dat[grant*DW +: DW] : '0;
  assign o_s_sel = fwd ? i_m_sel[grant*SW +: SW] : '0;
  assign o_m_dat = i_s_dat;
  assign o_grant = grant;
  assign o_busy  = (state != IDLE);

  always_comb begin
    o_m_ack        = '0;
    o_m_err        = '0;
    o_m_ack[grant] = s_stb && i_s_ack;
    o_m_err[grant] = timeout_hit;
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(NUM_M - 1);
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            last  <= pick;
            wdog  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!i_m_cyc[grant]) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state <= ERR;
          end else if (s_stb) begin
            wdog <= i_s_ack ? '0 : wdog + 1'b1;
          end
        end
        ERR: begin
          if (!i_m_cyc[grant]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
